// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared state encodings, SPI mode constants and default widths for the SPI master
package spi_master_pkg;

    localparam int W_CPU         = 32;
    localparam int W_COUNTER_DEF = 6;
    localparam int W_DIV_DEF     = 8;

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_SETUP = 2'd1,
        SPI_SHIFT = 2'd2,
        SPI_HOLD  = 2'd3
    } spi_state_e;

    // Mode value is {cpol, cpha}
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - CPU-side request/response bundle of the SPI master
interface spi_master_if #(
    parameter int W_Data = spi_master_pkg::W_CPU,
    parameter int W_Div  = spi_master_pkg::W_DIV_DEF
) ();

    logic [W_Data-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              cpol;
    logic              cpha;
    logic [W_Div-1:0]  clk_div;
    logic [W_Data-1:0] rx_data;
    logic              rx_valid;
    logic              busy;

    modport master (
        output tx_data, tx_valid, cpol, cpha, clk_div,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid, cpol, cpha, clk_div,
        output tx_ready, rx_data, rx_valid, busy
    );

endinterface

// File: rtl/spi_master_clk_gen.sv
// rtl/spi_master_clk_gen.sv - SCLK half-period timer and leading/trailing edge generator
module spi_master_clk_gen #(
    parameter int W_Div = spi_master_pkg::W_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             toggle_en,
    input  logic             cpol,
    input  logic [W_Div-1:0] clk_div,
    output logic             tick,
    output logic             lead_edge,
    output logic             trail_edge,
    output logic             spi_clk
);

    logic [W_Div-1:0] cnt_q;
    logic             sclk_q;

    assign tick       = en && (cnt_q == '0);
    assign lead_edge  = tick && toggle_en && (sclk_q == cpol);
    assign trail_edge = tick && toggle_en && (sclk_q != cpol);
    assign spi_clk    = en ? sclk_q : cpol;

    // While disabled the timer keeps reloading so the first tick lands clk_div+1 cycles after enable
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en) begin
            cnt_q  <= clk_div;
            sclk_q <= cpol;
        end else begin
            cnt_q <= tick ? clk_div : cnt_q - W_Div'(1);
            if (lead_edge || trail_edge) begin
                sclk_q <= ~sclk_q;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - full-duplex SPI master, modes 0-3, programmable divider; SPI_LOOPBACK_EN adds a loopback input
module spi_master
    import spi_master_pkg::*;
#(
    parameter int W_Data    = W_CPU,
    parameter int W_Counter = W_COUNTER_DEF,
    parameter int W_Div     = W_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst,
    spi_master_if.slave bus,
    output logic        spi_clk,
    output logic        spi_cs_n,
    output logic        MOSI_out,
    input  logic        MISO_in
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic        loopback
`endif
);

    spi_state_e           state_q, state_d;
    logic [W_Data-1:0]    tx_sh_q, rx_sh_q, rx_data_q;
    logic                 rx_valid_q, mosi_q, cpol_q, cpha_q;
    logic [W_Div-1:0]     div_q, div_sel;
    logic [W_Counter-1:0] bit_cnt_q;
    logic                 idle, accept, last_sample, sample_edge, drive_edge;
    logic                 cpol_sel, sample_bit, cs_n;
    logic                 tick, lead_edge, trail_edge;

`ifdef SPI_LOOPBACK_EN
    assign sample_bit = loopback ? mosi_q : MISO_in;
`else
    assign sample_bit = MISO_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SPI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idle        = (state_q == SPI_IDLE);
        cs_n        = idle;
        accept      = idle && !rx_valid_q && bus.tx_valid;
        last_sample = cpha_q ? (bit_cnt_q == W_Counter'(1)) : (bit_cnt_q == '0);
        sample_edge = cpha_q ? trail_edge : lead_edge;
        // In mode cpha=0 the last trailing edge keeps the final bit on the line
        drive_edge  = cpha_q ? lead_edge : (trail_edge && (bit_cnt_q != '0));
        case (state_q)
            SPI_IDLE:  if (accept) state_d = SPI_SETUP;
            SPI_SETUP: if (tick) state_d = SPI_SHIFT;
            SPI_SHIFT: if (trail_edge && last_sample) state_d = SPI_HOLD;
            SPI_HOLD:  if (tick) state_d = SPI_IDLE;
            default:   state_d = SPI_IDLE;
        endcase
    end

    // Timer loads from the live inputs while idle so the accept edge starts it with the new divider
    assign cpol_sel = idle ? bus.cpol : cpol_q;
    assign div_sel  = idle ? bus.clk_div : div_q;

    spi_master_clk_gen #(.W_Div(W_Div)) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (!idle),
        .toggle_en  (state_q == SPI_SHIFT),
        .cpol       (cpol_sel),
        .clk_div    (div_sel),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .spi_clk    (spi_clk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                SPI_IDLE: begin
                    if (accept) begin
                        cpol_q    <= bus.cpol;
                        cpha_q    <= bus.cpha;
                        div_q     <= bus.clk_div;
                        bit_cnt_q <= W_Counter'(W_Data);
                        rx_sh_q   <= '0;
                        if (!bus.cpha) begin
                            mosi_q  <= bus.tx_data[W_Data-1];
                            tx_sh_q <= bus.tx_data << 1;
                        end else begin
                            tx_sh_q <= bus.tx_data;
                        end
                    end
                end
                SPI_SHIFT: begin
                    if (sample_edge) begin
                        rx_sh_q   <= {rx_sh_q[W_Data-2:0], sample_bit};
                        bit_cnt_q <= bit_cnt_q - W_Counter'(1);
                    end
                    if (drive_edge) begin
                        mosi_q  <= tx_sh_q[W_Data-1];
                        tx_sh_q <= tx_sh_q << 1;
                    end
                end
                SPI_HOLD: begin
                    if (tick) begin
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                        mosi_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_cs_n     = cs_n;
    assign MOSI_out     = mosi_q;
    assign bus.tx_ready = idle && !rx_valid_q;
    assign bus.busy     = !idle;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule
